change_payout_ctrl: RTL and testbench

Sequences change payout for the vending machine. It accepts a change amount in kurus from the vending core and checks that the coin tubes can cover it. It then drives the coin hopper one coin at a time (1 TL = 100 kr first, then 50 kr), using a request/ack handshake per coin. It also tracks the stock in both coin tubes.

---
 rtl/vm_pkg.sv | 22 ++
 rtl/stock_counter.sv | 23 ++
 rtl/change_payout_ctrl.sv | 158 +++++++++++++++
 tb/tb_change_payout_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Types and constants shared between the vending core and the change payout block.
package vm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_SELECT,
      ST_WAIT_L,
      ST_WAIT_S,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_AMT   = 2'b01;
   localparam logic [1:0] ERR_STOCK = 2'b10;
   localparam logic [1:0] ERR_JAM   = 2'b11;

   localparam int KR_50 = 50;
   localparam int TL_1  = 100;

endpackage

// File: rtl/stock_counter.sv
// Coin tube stock: saturating up on refill, guarded down on consume; both at once hold.
module stock_counter #(
   parameter int W       = 8,
   parameter int RST_VAL = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         refill,
   input  logic         consume,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= W'(RST_VAL);
      end else if (refill && !consume) begin
         if (count != '1) count <= count + W'(1);
      end else if (consume && !refill) begin
         if (count != '0) count <= count - W'(1);
      end
   end

endmodule

// File: rtl/change_payout_ctrl.sv
// Change payout sequencer: checks tube coverage, then ejects 1 TL coins before 50 kr coins.
// Optional hopper-jam timeout is enabled by defining PAYOUT_TIMEOUT_EN.
module change_payout_ctrl
   import vm_pkg::*;
#(
   parameter int CHG_W        = 10,
   parameter int UNIT_L       = TL_1,
   parameter int UNIT_S       = KR_50,
   parameter int STOCK_W      = 8,
   parameter int INIT_STOCK_L = 10,
   parameter int INIT_STOCK_S = 10,
   parameter int TIMEOUT_CYC  = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               chg_valid,
   input  logic [CHG_W-1:0]   chg_amt,
   output logic               chg_ready,
   output logic               eject_l,
   output logic               eject_s,
   input  logic               hopper_ack,
   input  logic               refill_l,
   input  logic               refill_s,
   output logic [STOCK_W-1:0] stock_l,
   output logic [STOCK_W-1:0] stock_s,
   output logic [CHG_W-1:0]   remaining,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code
);

   state_t           state, state_nx;
   logic [CHG_W-1:0] remaining_nx;
   logic [1:0]       err_code_nx;
   logic             consume_l, consume_s;
   logic             timeout;
   logic [31:0]      amt32, nl, ns;

   // Coverage check: large coins first (limited by tube), the rest must fit in small coins.
   always_comb begin
      amt32 = 32'(remaining);
      nl    = amt32 / 32'(UNIT_L);
      if (nl > 32'(stock_l)) nl = 32'(stock_l);
      ns    = (amt32 - nl * 32'(UNIT_L)) / 32'(UNIT_S);
   end

`ifdef PAYOUT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] wait_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         wait_cnt <= '0;
      else if (state != ST_WAIT_L && state != ST_WAIT_S) wait_cnt <= '0;
      else if (!hopper_ack)                            wait_cnt <= wait_cnt + TW'(1);
   end

   // Firing on the TIMEOUT_CYC-th unacknowledged cycle keeps eject high exactly TIMEOUT_CYC cycles.
   assign timeout = !hopper_ack && (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         remaining <= '0;
         err_code  <= ERR_NONE;
      end else begin
         state     <= state_nx;
         remaining <= remaining_nx;
         err_code  <= err_code_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      remaining_nx = remaining;
      err_code_nx  = err_code;
      consume_l    = 1'b0;
      consume_s    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (chg_valid) begin
               remaining_nx = chg_amt;
               err_code_nx  = ERR_NONE;
               state_nx     = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (amt32 % 32'(UNIT_S) != 32'd0) begin
               err_code_nx = ERR_AMT;
               state_nx    = ST_ERR;
            end else if (ns > 32'(stock_s)) begin
               err_code_nx = ERR_STOCK;
               state_nx    = ST_ERR;
            end else if (remaining == '0) begin
               state_nx = ST_DONE;
            end else begin
               state_nx = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (remaining == '0)
               state_nx = ST_DONE;
            else if (remaining >= CHG_W'(UNIT_L) && stock_l != '0)
               state_nx = ST_WAIT_L;
            else
               state_nx = ST_WAIT_S;
         end
         ST_WAIT_L: begin
            if (hopper_ack) begin
               remaining_nx = remaining - CHG_W'(UNIT_L);
               consume_l    = 1'b1;
               state_nx     = ST_SELECT;
            end else if (timeout) begin
               err_code_nx = ERR_JAM;
               state_nx    = ST_ERR;
            end
         end
         ST_WAIT_S: begin
            if (hopper_ack) begin
               remaining_nx = remaining - CHG_W'(UNIT_S);
               consume_s    = 1'b1;
               state_nx     = ST_SELECT;
            end else if (timeout) begin
               err_code_nx = ERR_JAM;
               state_nx    = ST_ERR;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         ST_ERR:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   assign chg_ready = (state == ST_IDLE);
   assign eject_l   = (state == ST_WAIT_L);
   assign eject_s   = (state == ST_WAIT_S);
   assign done      = (state == ST_DONE);
   assign err       = (state == ST_ERR);

   stock_counter #(.W(STOCK_W), .RST_VAL(INIT_STOCK_L)) u_stock_l (
      .clk     (clk),
      .rst     (rst),
      .refill  (refill_l),
      .consume (consume_l),
      .count   (stock_l)
   );

   stock_counter #(.W(STOCK_W), .RST_VAL(INIT_STOCK_S)) u_stock_s (
      .clk     (clk),
      .rst     (rst),
      .refill  (refill_s),
      .consume (consume_s),
      .count   (stock_s)
   );

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Directed bench for change_payout_ctrl; tubes start at 5/5 and are walked through the payout cases.
module tb_change_payout_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       chg_valid = 1'b0;
   logic [9:0] chg_amt = '0;
   logic       chg_ready, eject_l, eject_s;
   logic       hopper_ack = 1'b0;
   logic       refill_l = 1'b0, refill_s = 1'b0;
   logic [7:0] stock_l, stock_s;
   logic [9:0] remaining;
   logic       done, err;
   logic [1:0] err_code;

   int checks = 0;
   int errors = 0;
   int both   = 0;

   always #5 clk = ~clk;

   change_payout_ctrl #(
      .CHG_W(10), .UNIT_L(100), .UNIT_S(50), .STOCK_W(8),
      .INIT_STOCK_L(5), .INIT_STOCK_S(5), .TIMEOUT_CYC(255)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .chg_valid  (chg_valid),
      .chg_amt    (chg_amt),
      .chg_ready  (chg_ready),
      .eject_l    (eject_l),
      .eject_s    (eject_s),
      .hopper_ack (hopper_ack),
      .refill_l   (refill_l),
      .refill_s   (refill_s),
      .stock_l    (stock_l),
      .stock_s    (stock_s),
      .remaining  (remaining),
      .done       (done),
      .err        (err),
      .err_code   (err_code)
   );

   always @(negedge clk) if (eject_l && eject_s) both++;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issue one request and play the hopper: ack on the 2nd cycle of each eject.
   task automatic pay(input int amt, input bit refill_on_ack,
                      output int nl, output int ns, output int fin, output bit got_done, output bit got_err);
      int hi;
      nl = 0; ns = 0; fin = -1; got_done = 0; got_err = 0; hi = 0;
      @(negedge clk);
      chg_valid = 1'b1;
      chg_amt   = 10'(amt);
      @(negedge clk);
      chg_valid = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (c > 0) @(negedge clk);
         hopper_ack = 1'b0;
         refill_l   = 1'b0;
         if (done || err) begin
            fin = c; got_done = done; got_err = err;
            break;
         end
         if (eject_l || eject_s) begin
            hi++;
            if (hi == 2) begin
               hopper_ack = 1'b1;
               if (eject_l) begin nl++; refill_l = refill_on_ack; end
               else ns++;
               hi = 0;
            end
         end else hi = 0;
      end
      hopper_ack = 1'b0;
      refill_l   = 1'b0;
      if (fin < 0) chk("pay_timeout", fin, 0);
   endtask

   initial begin
      int nl, ns, fin, seen;
      bit d, e;

      #12;
      chk("rst_ready",  int'(chg_ready), 1);
      chk("rst_stock_l", int'(stock_l), 5);
      chk("rst_stock_s", int'(stock_s), 5);
      chk("rst_rem",    int'(remaining), 0);
      chk("rst_code",   int'(err_code), 0);
      chk("rst_eject",  int'({eject_l, eject_s}), 0);
      @(negedge clk);
      rst = 1'b0;

      // 150 kr from 5/5: one 1 TL then one 50 kr
      pay(150, 1'b0, nl, ns, fin, d, e);
      chk("t1_nl", nl, 1);
      chk("t1_ns", ns, 1);
      chk("t1_done", int'(d), 1);
      chk("t1_rem", int'(remaining), 0);
      chk("t1_stock_l", int'(stock_l), 4);
      chk("t1_stock_s", int'(stock_s), 4);

      // drain the large tube, then top up small to 5
      pay(400, 1'b0, nl, ns, fin, d, e);
      chk("drain_nl", nl, 4);
      chk("drain_stock_l", int'(stock_l), 0);
      @(negedge clk); refill_s = 1'b1;
      @(negedge clk); refill_s = 1'b0;
      chk("refill_s", int'(stock_s), 5);

      // 200 kr with no large coins: four small coins
      pay(200, 1'b0, nl, ns, fin, d, e);
      chk("t2_nl", nl, 0);
      chk("t2_ns", ns, 4);
      chk("t2_done", int'(d), 1);
      chk("t2_stock_s", int'(stock_s), 1);

      // 75 kr is not a multiple of 50
      pay(75, 1'b0, nl, ns, fin, d, e);
      chk("t3_err", int'(e), 1);
      chk("t3_code", int'(err_code), 1);
      chk("t3_lat", fin, 1);
      chk("t3_ejects", nl + ns, 0);
      chk("t3_stock_l", int'(stock_l), 0);
      chk("t3_stock_s", int'(stock_s), 1);

      // 1/1 stock cannot cover 300 kr
      @(negedge clk); refill_l = 1'b1;
      @(negedge clk); refill_l = 1'b0;
      pay(300, 1'b0, nl, ns, fin, d, e);
      chk("t4_err", int'(e), 1);
      chk("t4_code", int'(err_code), 2);
      chk("t4_ejects", nl + ns, 0);
      pay(0, 1'b0, nl, ns, fin, d, e);
      chk("t4z_done", int'(d), 1);
      chk("t4z_lat", fin, 1);
      chk("t4z_ejects", nl + ns, 0);
      chk("t4z_code", int'(err_code), 0);

      // refill_l together with the ack: net zero on the large tube
      pay(100, 1'b1, nl, ns, fin, d, e);
      chk("t6a_nl", nl, 1);
      chk("t6a_done", int'(d), 1);
      chk("t6a_stock_l", int'(stock_l), 1);

      // async reset during WAIT_S
      @(negedge clk); chg_valid = 1'b1; chg_amt = 10'd50;
      @(negedge clk); chg_valid = 1'b0;
      seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         @(negedge clk);
         if (eject_s) seen = 1;
      end
      chk("t6b_ej_seen", seen, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6b_eject_s", int'(eject_s), 0);
      chk("t6b_ready", int'(chg_ready), 1);
      chk("t6b_stock_l", int'(stock_l), 5);
      chk("t6b_stock_s", int'(stock_s), 5);
      @(negedge clk); rst = 1'b0;

`ifdef PAYOUT_TIMEOUT_EN
      begin
         int hi_cyc;
         hi_cyc = 0;
         fin = -1;
         @(negedge clk); chg_valid = 1'b1; chg_amt = 10'd100;
         @(negedge clk); chg_valid = 1'b0;
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (eject_l) hi_cyc++;
            if (err) begin fin = c; break; end
         end
         chk("t5_err_seen", int'(fin >= 0), 1);
         chk("t5_hi_cyc", hi_cyc, 255);
         chk("t5_code", int'(err_code), 3);
         chk("t5_rem", int'(remaining), 100);
         chk("t5_stock_l", int'(stock_l), 5);
      end
`endif

      chk("excl_eject", both, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
